seg_scan_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 59 +++++
 rtl/bin2bcd_serial.sv | 41 ++++
 rtl/seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared glyph constants, conversion state encoding and helper functions
// for the vending display sequencer.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] FLD_NEED   = 2'd0;
  localparam logic [1:0] FLD_INPUT  = 2'd1;
  localparam logic [1:0] FLD_CHANGE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } conv_state_e;

  function automatic logic [7:0] seg_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    logic [3:0] r;
    if (n >= 4'd5) r = n + 4'd3;
    else           r = n;
    return r;
  endfunction

  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    return {nib_adj(b[11:8]), nib_adj(b[7:4]), nib_adj(b[3:0])};
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 converter: 8-bit binary to 3-digit BCD in 8 shift cycles.
// done is high during the final shift; bcd is valid from the following cycle.
module bin2bcd_serial
  import seg_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [7:0]  din,
  output logic        done,
  output logic [11:0] bcd
);

  logic [7:0]  bin_r;
  logic [11:0] bcd_r;
  logic [3:0]  cnt_r;
  logic [19:0] shifted_s;

  assign shifted_s = {bcd_adjust(bcd_r), bin_r} << 1;

  // load on start, then adjust-and-shift until the count runs out
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_r <= 8'd0;
      bcd_r <= 12'd0;
      cnt_r <= 4'd0;
    end else if (start) begin
      bin_r <= din;
      bcd_r <= 12'd0;
      cnt_r <= 4'd8;
    end else if (cnt_r != 4'd0) begin
      bcd_r <= shifted_s[19:8];
      bin_r <= shifted_s[7:0];
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign done = (cnt_r == 4'd1);
  assign bcd  = bcd_r;

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit 7-segment sequencer: snapshots three money values, converts them to
// BCD one field at a time and scans the committed buffer onto the digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int BLINK_FRAMES = 64,
  parameter bit LZB_EN       = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] need_money,
  input  logic [7:0] input_money,
  input  logic [7:0] change_money,
  input  logic       update_req,
  input  logic [2:0] blink_en,
  output logic       busy,
  output logic       update_done,
  output logic [7:0] bit_select,
  output logic [7:0] seg_select
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  conv_state_e state_r, state_nxt_s;
  logic        busy_r, done_r, pending_r;
  logic [1:0]  fld_r;
  logic [7:0]  snap_r [0:2];
  logic [3:0]  shd_ones_r [0:2];
  logic [3:0]  shd_tens_r [0:2];
  logic [2:0]  shd_ovf_r;
  logic [3:0]  disp_ones_r [0:2];
  logic [3:0]  disp_tens_r [0:2];
  logic [2:0]  disp_ovf_r;
  logic        start_s, snap_s, store_s, commit_s, cvt_done_s;
  logic [11:0] cvt_bcd_s;

  bin2bcd_serial u_bin2bcd (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start_s),
    .din       (snap_r[fld_r]),
    .done      (cvt_done_s),
    .bcd       (cvt_bcd_s)
  );

  // conversion sequencing; a commit with a request outstanding restarts at once
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    snap_s      = 1'b0;
    store_s     = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (update_req) begin
          snap_s      = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        start_s     = 1'b1;
        state_nxt_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cvt_done_s) state_nxt_s = ST_STORE;
        else            state_nxt_s = ST_SHIFT;
      end
      ST_STORE: begin
        store_s = 1'b1;
        if (fld_r == FLD_CHANGE) state_nxt_s = ST_COMMIT;
        else                     state_nxt_s = ST_LOAD;
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        if (pending_r || update_req) begin
          snap_s      = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM state, status outputs, snapshot, shadow and display buffers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pending_r   <= 1'b0;
      fld_r       <= FLD_NEED;
      snap_r      <= '{default: 8'd0};
      shd_ones_r  <= '{default: 4'd0};
      shd_tens_r  <= '{default: 4'd0};
      shd_ovf_r   <= 3'd0;
      disp_ones_r <= '{default: 4'd0};
      disp_tens_r <= '{default: 4'd0};
      disp_ovf_r  <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_COMMIT);
      if (snap_s) begin
        pending_r <= 1'b0;
        fld_r     <= FLD_NEED;
        snap_r[0] <= need_money;
        snap_r[1] <= input_money;
        snap_r[2] <= change_money;
      end else begin
        if (update_req && (state_r != ST_IDLE)) pending_r <= 1'b1;
        if (store_s && (fld_r != FLD_CHANGE)) fld_r <= fld_r + 2'd1;
      end
      if (store_s) begin
        shd_ones_r[fld_r] <= cvt_bcd_s[3:0];
        shd_tens_r[fld_r] <= cvt_bcd_s[7:4];
        shd_ovf_r[fld_r]  <= (cvt_bcd_s[11:8] != 4'd0);
      end
      if (commit_s) begin
        disp_ones_r <= shd_ones_r;
        disp_tens_r <= shd_tens_r;
        disp_ovf_r  <= shd_ovf_r;
      end
    end
  end

  logic [PW-1:0] presc_r;
  logic [2:0]    idx_r;
  logic [FW-1:0] frame_r;
  logic          blink_on_r, tc_s;
  logic [7:0]    bit_sel_r, seg_sel_r, seg_nxt_s;
  logic [1:0]    fld_s;
  logic          is_tens_s, is_sep_s;
  logic [3:0]    digit_s;

  assign tc_s = (presc_r == PW'(SCAN_DIV - 1));

  // digit slot prescaler, scan index, frame counter and blink phase
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_r    <= '0;
      idx_r      <= 3'd0;
      frame_r    <= '0;
      blink_on_r <= 1'b1;
    end else if (tc_s) begin
      presc_r <= '0;
      idx_r   <= idx_r + 3'd1;
      if (idx_r == 3'd7) begin
        if (frame_r == FW'(BLINK_FRAMES - 1)) begin
          frame_r    <= '0;
          blink_on_r <= ~blink_on_r;
        end else begin
          frame_r <= frame_r + FW'(1);
        end
      end
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // map the scan index onto a field and digit position
  always_comb begin
    fld_s     = FLD_NEED;
    is_tens_s = 1'b0;
    is_sep_s  = 1'b0;
    case (idx_r)
      3'd0: fld_s = FLD_NEED;
      3'd1: begin fld_s = FLD_NEED;   is_tens_s = 1'b1; end
      3'd3: fld_s = FLD_INPUT;
      3'd4: begin fld_s = FLD_INPUT;  is_tens_s = 1'b1; end
      3'd6: fld_s = FLD_CHANGE;
      3'd7: begin fld_s = FLD_CHANGE; is_tens_s = 1'b1; end
      default: is_sep_s = 1'b1;
    endcase
  end

  // segment pattern: blink beats overflow beats leading-zero blanking
  always_comb begin
    digit_s = is_tens_s ? disp_tens_r[fld_s] : disp_ones_r[fld_s];
    if (is_sep_s)                                  seg_nxt_s = SEG_DASH;
    else if (blink_en[fld_s] && !blink_on_r)       seg_nxt_s = SEG_BLANK;
    else if (disp_ovf_r[fld_s])                    seg_nxt_s = SEG_DASH;
    else if (LZB_EN && is_tens_s && digit_s == 4'd0) seg_nxt_s = SEG_BLANK;
    else                                           seg_nxt_s = seg_glyph(digit_s);
  end

  // registered pin drivers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_sel_r <= 8'hFF;
      seg_sel_r <= 8'hFF;
    end else begin
      bit_sel_r <= ~(8'd1 << idx_r);
      seg_sel_r <= seg_nxt_s;
    end
  end

  assign busy        = busy_r;
  assign update_done = done_r;
  assign bit_select  = bit_sel_r;
  assign seg_select  = seg_sel_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with a short scan divider.
module tb_seg_scan_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] need_money = 8'd0, input_money = 8'd0, change_money = 8'd0;
  logic       update_req = 1'b0;
  logic [2:0] blink_en = 3'b000;
  logic       busy, update_done;
  logic [7:0] bit_select, seg_select;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [7:0] glyph_t [0:9];

  seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2), .LZB_EN(1'b1)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .need_money   (need_money),
    .input_money  (input_money),
    .change_money (change_money),
    .update_req   (update_req),
    .blink_en     (blink_en),
    .busy         (busy),
    .update_done  (update_done),
    .bit_select   (bit_select),
    .seg_select   (seg_select)
  );

  always #5 sys_clk = ~sys_clk;

  // clock edges since reset release, used to model the blink phase
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 0;
    else            cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_update(input logic [7:0] nd, input logic [7:0] inp, input logic [7:0] chg,
                           output int lat);
    @(negedge sys_clk);
    need_money = nd; input_money = inp; change_money = chg;
    update_req = 1'b1;
    lat = -1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge sys_clk);
      update_req = 1'b0;
      if (n == 1) check_eq("busy_t1", {31'd0, busy}, 32'd1);
      if (update_done) begin
        lat = n;
        break;
      end
    end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_digit(input int i);
    logic [7:0] exp_bs;
    exp_bs = ~(8'd1 << i);
    for (int k = 0; k < 40 && bit_select !== exp_bs; k++) @(negedge sys_clk);
    check_eq($sformatf("bitsel%0d", i), {24'd0, bit_select}, {24'd0, exp_bs});
  endtask

  task automatic grab_frame(output logic [63:0] f, output int kc);
    kc = 0;
    for (int i = 0; i < 8; i++) begin
      wait_digit(i);
      f[i*8 +: 8] = seg_select;
      if (i == 3) kc = cyc;
    end
  endtask

  task automatic compare_frame(input string tag, input logic [63:0] f, input logic [63:0] exp);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("%s_d%0d", tag, i), {24'd0, f[i*8 +: 8]}, {24'd0, exp[i*8 +: 8]});
  endtask

  initial begin
    logic [63:0] fr;
    logic [63:0] exp_fr;
    logic [7:0]  blk;
    logic [7:0]  e0, e1, d0, d1;
    int lat, kc, nd, t1, t2;

    glyph_t[0] = 8'hC0; glyph_t[1] = 8'hF9; glyph_t[2] = 8'hA4; glyph_t[3] = 8'hB0;
    glyph_t[4] = 8'h99; glyph_t[5] = 8'h92; glyph_t[6] = 8'h82; glyph_t[7] = 8'hF8;
    glyph_t[8] = 8'h80; glyph_t[9] = 8'h90;

    // reset state
    repeat (3) @(negedge sys_clk);
    check_eq("rst_bitsel", {24'd0, bit_select}, 32'hFF);
    check_eq("rst_seg", {24'd0, seg_select}, 32'hFF);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, update_done}, 32'd0);
    sys_rst_n = 1'b1;
    grab_frame(fr, kc);
    compare_frame("rstbuf", fr, {8'hFF, 8'hC0, 8'hBF, 8'hFF, 8'hC0, 8'hBF, 8'hFF, 8'hC0});

    // basic conversion
    do_update(8'd35, 8'd20, 8'd5, lat);
    check_eq("lat1", lat, 32'd31);
    check_eq("idle_after", {31'd0, busy}, 32'd0);
    grab_frame(fr, kc);
    compare_frame("t1", fr, {8'hFF, 8'h92, 8'hBF, 8'hA4, 8'hC0, 8'hBF, 8'hB0, 8'h92});

    // need overflow
    do_update(8'd200, 8'd20, 8'd5, lat);
    check_eq("lat2", lat, 32'd31);
    grab_frame(fr, kc);
    compare_frame("ovf", fr, {8'hFF, 8'h92, 8'hBF, 8'hA4, 8'hC0, 8'hBF, 8'hBF, 8'hBF});

    // requests while busy merge into one restart
    @(negedge sys_clk);
    update_req = 1'b1;
    nd = 0; t1 = -1; t2 = -1;
    for (int n = 1; n <= 110; n++) begin
      @(negedge sys_clk);
      update_req = 1'b0;
      if (n == 5) begin input_money = 8'd99; update_req = 1'b1; end
      if (n == 10) update_req = 1'b1;
      if (update_done) begin
        nd++;
        if (nd == 1) t1 = n;
        else if (nd == 2) t2 = n;
      end
    end
    check_eq("pend_done1", t1, 32'd31);
    check_eq("pend_done2", t2, 32'd62);
    check_eq("pend_count", nd, 32'd2);
    grab_frame(fr, kc);
    compare_frame("pend", fr, {8'hFF, 8'h92, 8'hBF, 8'h90, 8'h90, 8'hBF, 8'hBF, 8'hBF});

    // blink on the input field: phase on for 2 frames after reset, then off for 2
    blink_en = 3'b010;
    repeat (2) @(negedge sys_clk);
    for (int m = 0; m < 6; m++) begin
      grab_frame(fr, kc);
      blk = (((kc / 64) % 2) == 0) ? 8'h90 : 8'hFF;
      exp_fr = {8'hFF, 8'h92, 8'hBF, blk, blk, 8'hBF, 8'hBF, 8'hBF};
      compare_frame($sformatf("blink%0d", m), fr, exp_fr);
    end
    blink_en = 3'b000;

    // sweep every need value
    for (int v = 0; v < 256; v++) begin
      do_update(v[7:0], 8'd20, 8'd5, lat);
      check_eq("sweep_lat", lat, 32'd31);
      wait_digit(0);
      d0 = seg_select;
      wait_digit(1);
      d1 = seg_select;
      if (v >= 100) begin
        e0 = 8'hBF; e1 = 8'hBF;
      end else begin
        e0 = glyph_t[v % 10];
        e1 = (v / 10 == 0) ? 8'hFF : glyph_t[v / 10];
      end
      check_eq($sformatf("sweep%0d_ones", v), {24'd0, d0}, {24'd0, e0});
      check_eq($sformatf("sweep%0d_tens", v), {24'd0, d1}, {24'd0, e1});
    end

    // reset in the middle of a conversion
    @(negedge sys_clk);
    need_money = 8'd35; input_money = 8'd20; change_money = 8'd5;
    update_req = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge sys_clk);
      update_req = 1'b0;
    end
    #2 sys_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_bitsel", {24'd0, bit_select}, 32'hFF);
    check_eq("mid_rst_seg", {24'd0, seg_select}, 32'hFF);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge sys_clk);
      if (update_done) nd++;
    end
    check_eq("mid_rst_nodone", nd, 32'd0);
    check_eq("mid_rst_idle", {31'd0, busy}, 32'd0);
    grab_frame(fr, kc);
    compare_frame("rst2", fr, {8'hFF, 8'hC0, 8'hBF, 8'hFF, 8'hC0, 8'hBF, 8'hFF, 8'hC0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
